// File: rtl/ahb3lite_interconnect_master_port.sv
// Purpose: master-side port of the AHB3-Lite multi-layer interconnect (one per AHB master).
// Latency: address phase passes through combinationally; one wait state per cycle the target is not granted.
// Backpressure: HREADYOUT low while an address phase is held for an ungranted slave port, else slave's HREADYOUT.
//
// Ports: HCLK/HRESET (sync, active-high); AHB slave interface toward the master (HSEL..HREADY in,
//   HRDATA/HREADYOUT/HRESP out); address map slvHADDRbase/slvHADDRmask; broadcast address/data phase
//   slvH* out with one-hot slvHSEL; per-slave return slvHRDATA/slvHREADYOUT/slvHRESP in; arbiter
//   handshake granted in / can_switch out; mstpriority passed through to slvpriority.
// Optional: define AHB3LITE_MSTPORT_ERROR_RESPONSE_EN to answer unmapped accesses with a two-cycle
//   ERROR response; otherwise they complete with zero wait states, OKAY and HRDATA=0.
module ahb3lite_interconnect_master_port #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 3,
    parameter int SLAVES     = 8
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic [$clog2(MASTERS-1):0]  mstpriority,

    input  logic                        HSEL,
    input  logic [HADDR_SIZE-1:0]       HADDR,
    input  logic [HDATA_SIZE-1:0]       HWDATA,
    input  logic                        HWRITE,
    input  logic [2:0]                  HSIZE,
    input  logic [2:0]                  HBURST,
    input  logic [3:0]                  HPROT,
    input  logic [1:0]                  HTRANS,
    input  logic                        HMASTLOCK,
    input  logic                        HREADY,
    output logic [HDATA_SIZE-1:0]       HRDATA,
    output logic                        HREADYOUT,
    output logic                        HRESP,

    input  logic [HADDR_SIZE-1:0]       slvHADDRbase [SLAVES],
    input  logic [HADDR_SIZE-1:0]       slvHADDRmask [SLAVES],

    output logic [$clog2(MASTERS-1):0]  slvpriority,
    output logic [SLAVES-1:0]           slvHSEL,
    output logic [HADDR_SIZE-1:0]       slvHADDR,
    output logic [HDATA_SIZE-1:0]       slvHWDATA,
    output logic                        slvHWRITE,
    output logic [2:0]                  slvHSIZE,
    output logic [2:0]                  slvHBURST,
    output logic [3:0]                  slvHPROT,
    output logic [1:0]                  slvHTRANS,
    output logic                        slvHMASTLOCK,
    output logic                        slvHREADY,
    input  logic [HDATA_SIZE-1:0]       slvHRDATA [SLAVES],
    input  logic [SLAVES-1:0]           slvHREADYOUT,
    input  logic [SLAVES-1:0]           slvHRESP,

    output logic [SLAVES-1:0]           can_switch,
    input  logic [SLAVES-1:0]           granted
);

    localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

`ifdef AHB3LITE_MSTPORT_ERROR_RESPONSE_EN
    typedef enum logic [1:0] {NORMAL, HOLD, ERR1, ERR2} state_t;
`else
    typedef enum logic [1:0] {NORMAL, HOLD} state_t;
`endif

    state_t                 state;

    // data phase owner: dp_vld=0 means IDLE/BUSY/unmapped, answered locally with OKAY
    logic                   dp_vld;
    logic [IDX_W-1:0]       dp_idx;

    // address phase parked while the target slave port has not granted us
    logic [IDX_W-1:0]       hold_idx;
    logic [HADDR_SIZE-1:0]  h_addr;
    logic                   h_write;
    logic [2:0]             h_size;
    logic [2:0]             h_burst;
    logic [3:0]             h_prot;
    logic [1:0]             h_trans;
    logic                   h_lock;

    logic                   dec_vld;
    logic [IDX_W-1:0]       dec_idx;
    logic                   req;

    // lowest-index match wins: scan downward so the last hit is the lowest index
    always_comb begin
        dec_vld = 1'b0;
        dec_idx = '0;
        for (int s = SLAVES-1; s >= 0; s--) begin
            if (HSEL && ((HADDR & slvHADDRmask[s]) == (slvHADDRbase[s] & slvHADDRmask[s]))) begin
                dec_vld = 1'b1;
                dec_idx = IDX_W'(s);
            end
        end
    end

    assign req = HSEL & HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= NORMAL;
            dp_vld   <= 1'b0;
            dp_idx   <= '0;
            hold_idx <= '0;
            h_addr   <= '0;
            h_write  <= 1'b0;
            h_size   <= '0;
            h_burst  <= '0;
            h_prot   <= '0;
            h_trans  <= HTRANS_IDLE;
            h_lock   <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (granted[hold_idx] && slvHREADYOUT[hold_idx]) begin
                        state  <= NORMAL;
                        dp_vld <= 1'b1;
                        dp_idx <= hold_idx;
                    end
                end
`ifdef AHB3LITE_MSTPORT_ERROR_RESPONSE_EN
                ERR1: state <= ERR2;
`endif
                // NORMAL, and the last error cycle, which already lets the next address phase through
                default: begin
                    state <= NORMAL;
                    if (HREADY) begin
                        dp_vld <= 1'b0;
                        if (req && dec_vld) begin
                            if (granted[dec_idx]) begin
                                dp_vld <= 1'b1;
                                dp_idx <= dec_idx;
                            end else begin
                                state    <= HOLD;
                                hold_idx <= dec_idx;
                                h_addr   <= HADDR;
                                h_write  <= HWRITE;
                                h_size   <= HSIZE;
                                h_burst  <= HBURST;
                                h_prot   <= HPROT;
                                h_trans  <= HTRANS;
                                h_lock   <= HMASTLOCK;
                            end
                        end
`ifdef AHB3LITE_MSTPORT_ERROR_RESPONSE_EN
                        else if (req) begin
                            state <= ERR1;
                        end
`endif
                    end
                end
            endcase
        end
    end

    always_comb begin
        slvHADDR     = HADDR;
        slvHWRITE    = HWRITE;
        slvHSIZE     = HSIZE;
        slvHBURST    = HBURST;
        slvHPROT     = HPROT;
        slvHTRANS    = HTRANS;
        slvHMASTLOCK = HMASTLOCK;
        slvHSEL      = dec_vld ? (SLAVES'(1) << dec_idx) : '0;
        HRDATA       = dp_vld ? slvHRDATA[dp_idx]    : '0;
        HREADYOUT    = dp_vld ? slvHREADYOUT[dp_idx] : 1'b1;
        HRESP        = dp_vld ? slvHRESP[dp_idx]     : 1'b0;
        case (state)
            HOLD: begin
                slvHADDR     = h_addr;
                slvHWRITE    = h_write;
                slvHSIZE     = h_size;
                slvHBURST    = h_burst;
                slvHPROT     = h_prot;
                slvHMASTLOCK = h_lock;
                // the slave port sees a fresh transfer, so a SEQ beat must restart as NONSEQ
                slvHTRANS    = (h_trans == HTRANS_SEQ) ? HTRANS_NONSEQ : h_trans;
                slvHSEL      = SLAVES'(1) << hold_idx;
                HREADYOUT    = 1'b0;
                HRESP        = 1'b0;
                HRDATA       = '0;
            end
`ifdef AHB3LITE_MSTPORT_ERROR_RESPONSE_EN
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                HRDATA    = '0;
            end
            ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
                HRDATA    = '0;
            end
`endif
            default: ;
        endcase
    end

    // the slave port qualifies acceptance of a held phase with its grant and its own HREADYOUT
    assign slvHREADY   = HREADYOUT;
    assign slvHWDATA   = HWDATA;
    assign slvpriority = mstpriority;

    always_comb begin
        for (int s = 0; s < SLAVES; s++) begin
            can_switch[s] = !(slvHSEL[s] & (slvHMASTLOCK | (slvHTRANS == HTRANS_SEQ) |
                                            (slvHTRANS == HTRANS_BUSY)));
        end
        if (state == HOLD) can_switch[hold_idx] = 1'b0;
    end

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Purpose: self-checking bench for ahb3lite_interconnect_master_port (directed cases, then random traffic).
// Latency: model predicts every output each cycle; state advances at each HCLK rising edge.
// Backpressure: the bench master holds its address phase whenever the predicted HREADYOUT is low.
module tb_ahb3lite_interconnect_master_port;

    localparam int SL = 8;

    logic        HCLK, HRESET;
    logic [1:0]  mstpriority;
    logic        HSEL, HWRITE, HMASTLOCK, HREADY;
    logic [31:0] HADDR, HWDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP;
    logic [31:0] slvHADDRbase [SL];
    logic [31:0] slvHADDRmask [SL];
    logic [1:0]  slvpriority;
    logic [SL-1:0] slvHSEL;
    logic [31:0] slvHADDR, slvHWDATA;
    logic        slvHWRITE, slvHMASTLOCK, slvHREADY;
    logic [2:0]  slvHSIZE, slvHBURST;
    logic [3:0]  slvHPROT;
    logic [1:0]  slvHTRANS;
    logic [31:0] slvHRDATA [SL];
    logic [SL-1:0] slvHREADYOUT, slvHRESP, can_switch, granted;

    ahb3lite_interconnect_master_port #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(3), .SLAVES(SL)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .mstpriority(mstpriority),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .slvHADDRbase(slvHADDRbase), .slvHADDRmask(slvHADDRmask),
        .slvpriority(slvpriority), .slvHSEL(slvHSEL), .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA),
        .slvHWRITE(slvHWRITE), .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST), .slvHPROT(slvHPROT),
        .slvHTRANS(slvHTRANS), .slvHMASTLOCK(slvHMASTLOCK), .slvHREADY(slvHREADY),
        .slvHRDATA(slvHRDATA), .slvHREADYOUT(slvHREADYOUT), .slvHRESP(slvHRESP),
        .can_switch(can_switch), .granted(granted)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_hold: an address phase is parked; m_dp: slave owning the data phase (-1: answered locally);
    // m_err: remaining cycles of an ERROR response
    bit          m_hold;
    int          m_hslave, m_dp, m_err;
    logic [31:0] m_haddr;
    logic        m_hwrite, m_hlock;
    logic [9:0]  m_hctl;
    bit          bus_free;

    logic [31:0]   e_rdata, e_addr;
    logic          e_rdy, e_resp, e_write, e_lock;
    logic [1:0]    e_trans;
    logic [9:0]    e_ctl;
    logic [SL-1:0] e_sel, e_cs;

    function automatic int decode(input logic [31:0] a);
        for (int s = 0; s < SL; s++)
            if ((a & slvHADDRmask[s]) == (slvHADDRbase[s] & slvHADDRmask[s])) return s;
        return -1;
    endfunction

    task automatic predict();
        int tgt;
        if (m_hold) begin
            e_sel = SL'(1) << m_hslave; e_addr = m_haddr; e_write = m_hwrite;
            e_lock = m_hlock; e_ctl = m_hctl; e_trans = 2'b10;
            e_rdy = 1'b0; e_resp = 1'b0; e_rdata = '0;
        end else begin
            tgt = HSEL ? decode(HADDR) : -1;
            e_sel = (tgt >= 0) ? (SL'(1) << tgt) : '0;
            e_addr = HADDR; e_write = HWRITE; e_lock = HMASTLOCK;
            e_ctl = {HSIZE, HBURST, HPROT}; e_trans = HTRANS;
            if (m_err == 2)      begin e_rdy = 1'b0; e_resp = 1'b1; e_rdata = '0; end
            else if (m_err == 1) begin e_rdy = 1'b1; e_resp = 1'b1; e_rdata = '0; end
            else if (m_dp >= 0)  begin e_rdy = slvHREADYOUT[m_dp]; e_resp = slvHRESP[m_dp]; e_rdata = slvHRDATA[m_dp]; end
            else                 begin e_rdy = 1'b1; e_resp = 1'b0; e_rdata = '0; end
        end
        for (int s = 0; s < SL; s++)
            e_cs[s] = !(e_sel[s] && (e_lock || e_trans == 2'b11 || e_trans == 2'b01));
        if (m_hold) e_cs[m_hslave] = 1'b0;
    endtask

    task automatic model_edge();
        int tgt;
        if (HRESET) begin
            m_hold = 0; m_dp = -1; m_err = 0;
        end else if (m_hold) begin
            if (granted[m_hslave] && slvHREADYOUT[m_hslave]) begin m_hold = 0; m_dp = m_hslave; end
        end else if (m_err == 2) begin
            m_err = 1;
        end else begin
            m_err = 0;
            if (HREADY) begin
                m_dp = -1;
                if (HSEL && HTRANS[1]) begin
                    tgt = decode(HADDR);
                    if (tgt < 0) begin
`ifdef AHB3LITE_MSTPORT_ERROR_RESPONSE_EN
                        m_err = 2;
`endif
                    end else if (granted[tgt]) begin
                        m_dp = tgt;
                    end else begin
                        m_hold = 1; m_hslave = tgt; m_haddr = HADDR; m_hwrite = HWRITE;
                        m_hlock = HMASTLOCK; m_hctl = {HSIZE, HBURST, HPROT};
                    end
                end
            end
        end
    endtask

    // inputs are already driven; predict, drive HREADY from the prediction, compare
    task automatic settle(input bit do_chk);
        predict();
        HREADY = e_rdy;
        #1;
        if (do_chk) begin
            check("HREADYOUT",    64'(HREADYOUT),    64'(e_rdy));
            check("HRESP",        64'(HRESP),        64'(e_resp));
            check("HRDATA",       64'(HRDATA),       64'(e_rdata));
            check("slvHSEL",      64'(slvHSEL),      64'(e_sel));
            check("slvHADDR",     64'(slvHADDR),     64'(e_addr));
            check("slvHTRANS",    64'(slvHTRANS),    64'(e_trans));
            check("slvHWRITE",    64'(slvHWRITE),    64'(e_write));
            check("slvHMASTLOCK", 64'(slvHMASTLOCK), 64'(e_lock));
            check("slvHctl",      64'({slvHSIZE, slvHBURST, slvHPROT}), 64'(e_ctl));
            check("slvHWDATA",    64'(slvHWDATA),    64'(HWDATA));
            check("slvHREADY",    64'(slvHREADY),    64'(e_rdy));
            check("can_switch",   64'(can_switch),   64'(e_cs));
            check("slvpriority",  64'(slvpriority),  64'(mstpriority));
        end
    endtask

    task automatic adv();
        @(posedge HCLK);
        bus_free = HREADY;
        model_edge();
        @(negedge HCLK);
    endtask

    task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic wr);
        HSEL = 1'b1; HTRANS = tr; HADDR = a; HWRITE = wr;
    endtask

    initial begin
        HRESET = 1'b1; mstpriority = 2'd2; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
        HSIZE = 3'b010; HBURST = 3'b000; HPROT = 4'b0011; HTRANS = 2'b00; HMASTLOCK = 1'b0;
        HREADY = 1'b1; granted = '1; slvHREADYOUT = '1; slvHRESP = '0;
        m_hold = 0; m_dp = -1; m_err = 0; m_hslave = 0; bus_free = 1;
        m_haddr = '0; m_hwrite = 0; m_hlock = 0; m_hctl = '0;
        // slaves 0..7 at 0xs000_0000 (0x8..0xF unmapped); slave 5 overlaps 2/3 to exercise priority
        for (int s = 0; s < SL; s++) begin
            slvHADDRbase[s] = 32'(s) << 28;
            slvHADDRmask[s] = 32'hF000_0000;
            slvHRDATA[s]    = 32'h1111_1111 * 32'(s);
        end
        slvHADDRbase[5] = 32'h2000_0000; slvHADDRmask[5] = 32'hE000_0000;
        slvHRDATA[2] = 32'hCAFE_BABE;

        // reset for 2 cycles
        settle(0); adv();
        settle(1); adv();
        HRESET = 1'b0;
        settle(1);
        check("rst_rdy", 64'(HREADYOUT), 64'(1));
        check("rst_resp", 64'(HRESP), 64'(0));
        check("rst_sel", 64'(slvHSEL), 64'(0));
        check("rst_cs", 64'(can_switch), 64'(8'hFF));
        adv();

        // granted read to slave 2
        drive(2'b10, 32'h2000_0010, 1'b0);
        settle(1); check("rd_sel", 64'(slvHSEL), 64'(8'h04)); adv();
        HTRANS = 2'b00;
        settle(1);
        check("rd_data", 64'(HRDATA), 64'(32'hCAFE_BABE));
        check("rd_rdy", 64'(HREADYOUT), 64'(1));
        adv();

        // SEQ write held for 3 cycles until slave 2 grants
        granted = 8'hFB;
        drive(2'b11, 32'h2000_0014, 1'b1);
        settle(1); adv();
        drive(2'b00, 32'h5555_0000, 1'b0); HWDATA = 32'hDEAD_0014;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) granted = 8'hFF;
            settle(1);
            check("hold_rdy", 64'(HREADYOUT), 64'(0));
            check("hold_trans", 64'(slvHTRANS), 64'(2'b10));
            check("hold_addr", 64'(slvHADDR), 64'(32'h2000_0014));
            check("hold_sel", 64'(slvHSEL), 64'(8'h04));
            check("hold_cs2", 64'(can_switch[2]), 64'(0));
            adv();
        end
        settle(1);
        check("wr_dp_rdy", 64'(HREADYOUT), 64'(1));
        check("wr_hwdata", 64'(slvHWDATA), 64'(32'hDEAD_0014));
        adv();

        // unmapped write
        drive(2'b10, 32'h9000_0000, 1'b1);
        settle(1); check("unm_sel", 64'(slvHSEL), 64'(0)); adv();
        HTRANS = 2'b00;
`ifdef AHB3LITE_MSTPORT_ERROR_RESPONSE_EN
        settle(1);
        check("err1_rdy", 64'(HREADYOUT), 64'(0)); check("err1_resp", 64'(HRESP), 64'(1));
        adv();
        settle(1);
        check("err2_rdy", 64'(HREADYOUT), 64'(1)); check("err2_resp", 64'(HRESP), 64'(1));
        adv();
`else
        settle(1);
        check("unm_rdy", 64'(HREADYOUT), 64'(1)); check("unm_resp", 64'(HRESP), 64'(0));
        check("unm_data", 64'(HRDATA), 64'(0));
        adv();
`endif

        // locked INCR4 to slave 1
        HMASTLOCK = 1'b1; HBURST = 3'b011;
        for (int b = 0; b < 4; b++) begin
            drive((b == 0) ? 2'b10 : 2'b11, 32'h1000_0000 + 32'(4 * b), 1'b0);
            settle(1); check("lock_cs1", 64'(can_switch[1]), 64'(0)); adv();
        end
        HTRANS = 2'b00; HMASTLOCK = 1'b0; HBURST = 3'b000;
        settle(1); check("unlock_cs1", 64'(can_switch[1]), 64'(1)); adv();

        // reset while holding a transfer for slave 3
        granted = 8'hF7;
        drive(2'b10, 32'h3000_0000, 1'b1);
        settle(1); adv();
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00;
        settle(1); check("prerst_rdy", 64'(HREADYOUT), 64'(0)); adv();
        HRESET = 1'b0; granted = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            settle(1);
            check("postrst_sel", 64'(slvHSEL), 64'(0));
            check("postrst_rdy", 64'(HREADYOUT), 64'(1));
            check("postrst_trans", 64'(slvHTRANS), 64'(2'b00));
            adv();
        end

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            if (bus_free) begin
                HTRANS    = 2'($urandom_range(0, 3));
                HSEL      = HTRANS[1] ? 1'b1 : 1'($urandom_range(0, 1));
                HADDR     = (32'($urandom_range(0, 15)) << 28) | ($urandom & 32'h0000_0FFC);
                HWRITE    = 1'($urandom_range(0, 1));
                HMASTLOCK = ($urandom_range(0, 3) == 0);
                HSIZE     = 3'($urandom_range(0, 2));
                HBURST    = 3'($urandom_range(0, 7));
                HPROT     = 4'($urandom);
            end
            HWDATA       = $urandom;
            granted      = SL'($urandom);
            slvHREADYOUT = SL'($urandom | $urandom);
            slvHRESP     = SL'($urandom & $urandom & $urandom);
            for (int s = 0; s < SL; s++) slvHRDATA[s] = $urandom;
            settle(1);
            adv();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
